td_core: RTL and testbench
==========================

# td_core

Parametrised multi-cycle core that generalises the existing 4-bit two-register datapath. It adds configurable data width, address width and register count, a fetch/execute state machine with a req/ack instruction-memory handshake, and register-to-register ALU operations with borrow. It also adds a HALT state. It sits between the instruction ROM (or a wait-stated memory) and the board switch/LED pins, and replaces the combinational next-state logic plus its external state register.

## Interface
- DATA_W, 4, width of registers, immediate, switch input and output port
- ADDR_W, 4, width of instruction pointer and instruction-memory address
- NREG, 2, number of general registers (≥2); RSEL = $clog2(NREG)
- Instruction word width INSTR_W = 4 + 2*RSEL + DATA_W, fields {op[3:0], dst, src, imm}, MSB first
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- run_en  in  1  permits starting a new fetch
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address (= ip)
- imem_ack  in  1  fetch complete; imem_data valid this cycle
- imem_data  in  INSTR_W  instruction word
- sw_in  in  DATA_W  switch input
- out_port  out  DATA_W  registered output port
- out_valid  out  1  one-cycle pulse when out_port is written
- halted  out  1  high while in HALT

## Operation
- States: FETCH, EXEC, HALT.
  - FETCH: imem_req=1 when run_en=1 or a request is already outstanding. On imem_ack, latch imem_data and go to EXEC.
  - EXEC: one cycle. Update regs, cf, ip and out, then go to FETCH. HALT opcode goes to HALT instead.
- HALT is left only by reset.
- Opcodes; r = register file, cf = carry flag:
  - 0 ADD_IMM: {cf, r[dst]} = r[dst] + imm
  - 1 MOV_IMM: r[dst] = imm
  - 2 MOV_REG: r[dst] = r[src]
  - 3 IN: r[dst] = sw_in
  - 4 OUT_REG: out = r[src]
  - 5 OUT_IMM: out = imm
  - 6 JMP: ip = imm
  - 7 JNC: ip = cf ? ip+1 : imm
  - 8 ADD_REG: {cf, r[dst]} = r[dst] + r[src]
  - 9 SUB_IMM: r[dst] = r[dst] - imm, cf = borrow (1 when imm > r[dst])
  - 10 HALT
  - 11–15: NOP
- cf is cleared by every EXEC except opcodes 0, 8 and 9, including NOP, JNC and HALT. JNC tests the cf value from before the instruction.
- ip = ip+1 mod 2^ADDR_W unless a jump is taken. Wrap from max to 0 is legal.
- Jump target is imm zero-extended or truncated to ADDR_W.
- dst and src values ≥ NREG: writes are dropped and reads return 0.
- out_valid pulses for exactly the cycle after an EXEC of opcode 4 or 5, including when the value is unchanged.

## Timing
- Reset values: imem_req=0, imem_addr=0, out_port=0, out_valid=0, halted=0. All regs, cf and ip are 0. State is FETCH.
- rst_n assertion takes effect immediately (asynchronous), including mid-fetch with a request outstanding. imem_req drops without waiting for ack.
- Handshake:
  - imem_addr is stable while imem_req=1.
  - Once raised, imem_req stays high until the ack cycle, even if run_en falls.
  - imem_req drops in the cycle after ack.
  - imem_ack while imem_req=0 is ignored.
- Zero-wait memory (ack tied to req) gives 2 cycles per instruction. Each wait cycle adds 1.
- Architectural effects of an instruction are visible the cycle after its EXEC cycle.
- run_en=0 in FETCH holds the core idle with imem_req=0. run_en has no effect in EXEC or HALT.

## Configuration
- IN_SYNC_EN defined: sw_in passes through a 2-flop synchroniser, reset to 0. IN reads the synchronised value, so sw_in changes are visible to IN executed ≥2 cycles later.
- IN_SYNC_EN undefined: IN samples sw_in directly in the EXEC cycle.

## Test plan
- Defaults, zero-wait memory.
  - Program MOV_IMM r0,3; ADD_IMM r0,14; JNC 0; OUT_REG r0 → cf=1 after ADD, r0=1, JNC falls through, out_port=1 with a single out_valid pulse. Total 8 cycles from first req.
- SUB_IMM r1,5 with r1=2 → r1=13 (DATA_W=4), cf=1. Next MOV_IMM clears cf.
- Ack delayed 3 cycles with run_en dropped mid-request → imem_req and imem_addr held until ack. No new req afterwards until run_en=1.
- DATA_W=8, ADDR_W=6, NREG=4.
  - ADD_REG r3,r2 with 200+100 → r3=44, cf=1.
  - JMP 63, then NOP at 63 → ip wraps to 0.
- HALT → halted=1 next cycle, imem_req stays 0 indefinitely.
  - rst_n pulse mid-HALT → all outputs return to reset values, fetch restarts at 0.
- With IN_SYNC_EN: sw_in changes 1 cycle before IN's EXEC → old value loaded. Without IN_SYNC_EN: new value loaded.

Source files
------------

// File: rtl/td_core.sv
// td_core: parametrised fetch/execute core with a req/ack instruction fetch, a register file and HALT.
// Build option IN_SYNC_EN: sw_in passes through a 2-flop synchroniser before IN reads it.
module td_core #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4,
    parameter int NREG   = 2,
    localparam int RSEL    = (NREG > 1) ? $clog2(NREG) : 1,
    localparam int INSTR_W = 4 + 2 * RSEL + DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run_en,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic [DATA_W-1:0]  sw_in,
    output logic [DATA_W-1:0]  out_port,
    output logic               out_valid,
    output logic               halted
);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

    localparam logic [3:0] OP_ADD_IMM = 4'd0;
    localparam logic [3:0] OP_MOV_IMM = 4'd1;
    localparam logic [3:0] OP_MOV_REG = 4'd2;
    localparam logic [3:0] OP_IN      = 4'd3;
    localparam logic [3:0] OP_OUT_REG = 4'd4;
    localparam logic [3:0] OP_OUT_IMM = 4'd5;
    localparam logic [3:0] OP_JMP     = 4'd6;
    localparam logic [3:0] OP_JNC     = 4'd7;
    localparam logic [3:0] OP_ADD_REG = 4'd8;
    localparam logic [3:0] OP_SUB_IMM = 4'd9;
    localparam logic [3:0] OP_HALT    = 4'd10;

    state_t              state;
    logic                pending;
    logic [INSTR_W-1:0]  ir;
    logic [ADDR_W-1:0]   ip;
    logic                cf;
    logic [DATA_W-1:0]   regs [NREG];
    logic [DATA_W-1:0]   sw_val;

    logic [3:0]          op;
    logic [RSEL-1:0]     dst;
    logic [RSEL-1:0]     src;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   dst_val;
    logic [DATA_W-1:0]   src_val;
    logic [ADDR_W+DATA_W-1:0] imm_wide;
    logic [ADDR_W-1:0]   jmp_target;

    logic                wr_en;
    logic [DATA_W-1:0]   wr_data;
    logic                cf_next;
    logic [ADDR_W-1:0]   ip_next;
    logic                out_we;
    logic [DATA_W-1:0]   out_data;

`ifdef IN_SYNC_EN
    logic [DATA_W-1:0] sw_s1;
    logic [DATA_W-1:0] sw_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= sw_in;
            sw_s2 <= sw_s1;
        end
    end

    assign sw_val = sw_s2;
`else
    assign sw_val = sw_in;
`endif

    // A request, once raised, is held by pending until acked; reset kills it at once.
    assign imem_req  = rst_n && (state == S_FETCH) && (run_en || pending);
    assign imem_addr = ip;

    assign op  = ir[INSTR_W-1 -: 4];
    assign dst = ir[DATA_W+RSEL +: RSEL];
    assign src = ir[DATA_W +: RSEL];
    assign imm = ir[DATA_W-1:0];

    assign imm_wide   = {{ADDR_W{1'b0}}, imm};
    assign jmp_target = imm_wide[ADDR_W-1:0];

    // Selectors that name no register read as zero.
    always_comb begin
        dst_val = '0;
        src_val = '0;
        for (int i = 0; i < NREG; i++) begin
            if (int'(dst) == i) dst_val = regs[i];
            if (int'(src) == i) src_val = regs[i];
        end
    end

    always_comb begin
        wr_en    = 1'b0;
        wr_data  = dst_val;
        cf_next  = 1'b0;
        ip_next  = ip + ADDR_W'(1);
        out_we   = 1'b0;
        out_data = out_port;
        case (op)
            OP_ADD_IMM: begin
                {cf_next, wr_data} = {1'b0, dst_val} + {1'b0, imm};
                wr_en = 1'b1;
            end
            OP_MOV_IMM: begin
                wr_data = imm;
                wr_en   = 1'b1;
            end
            OP_MOV_REG: begin
                wr_data = src_val;
                wr_en   = 1'b1;
            end
            OP_IN: begin
                wr_data = sw_val;
                wr_en   = 1'b1;
            end
            OP_OUT_REG: begin
                out_data = src_val;
                out_we   = 1'b1;
            end
            OP_OUT_IMM: begin
                out_data = imm;
                out_we   = 1'b1;
            end
            OP_JMP: ip_next = jmp_target;
            OP_JNC: if (!cf) ip_next = jmp_target;
            OP_ADD_REG: begin
                {cf_next, wr_data} = {1'b0, dst_val} + {1'b0, src_val};
                wr_en = 1'b1;
            end
            OP_SUB_IMM: begin
                // The extra top bit of the difference is the borrow.
                {cf_next, wr_data} = {1'b0, dst_val} - {1'b0, imm};
                wr_en = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            pending   <= 1'b0;
            ir        <= '0;
            ip        <= '0;
            cf        <= 1'b0;
            out_port  <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (imem_req && imem_ack) begin
                        ir      <= imem_data;
                        pending <= 1'b0;
                        state   <= S_EXEC;
                    end else if (imem_req) begin
                        pending <= 1'b1;
                    end
                end
                S_EXEC: begin
                    cf <= cf_next;
                    ip <= ip_next;
                    for (int i = 0; i < NREG; i++) begin
                        if (wr_en && int'(dst) == i) regs[i] <= wr_data;
                    end
                    if (out_we) begin
                        out_port  <= out_data;
                        out_valid <= 1'b1;
                    end
                    if (op == OP_HALT) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                default: state <= S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_td_core.sv
// Bench for td_core: a default-size core and an 8-bit/6-bit/4-register core against an integer
// reference model of the instruction set, with directed handshake/reset steps and random programs.
module tb_td_core;

    localparam int DW0 = 4, AW0 = 4, NR0 = 2, IW0 = 10;
    localparam int DW1 = 8, AW1 = 6, NR1 = 4, IW1 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic run_en0, run_en1;
    logic req0, req1, ack0, ack1;
    logic out_valid0, out_valid1, halted0, halted1;
    logic [AW0-1:0] addr0;
    logic [AW1-1:0] addr1;
    logic [IW0-1:0] data0;
    logic [IW1-1:0] data1;
    logic [DW0-1:0] sw0, out0;
    logic [DW1-1:0] sw1, out1;

    logic [IW0-1:0] prog0 [16];
    logic [IW1-1:0] prog1 [64];
    int   wait_n = 0;
    logic spur = 1'b0;
    int   wcnt0 = 0, wcnt1 = 0;
    int   sw_val = 0;
    int   cyc = 0;

    int checks = 0, failures = 0;
    int sel, dw, aw, nr, rs;
    bit drop_run = 0, rand_sw = 0;
    int last_fetch_cyc, last_chk_cyc, t0;

    int mr [4];
    int mcf, mip, mout, mvalid, mhalt;

    // Wait-stated memory: ack after wait_n request cycles; spur drives a stray ack.
    assign ack0  = (req0 && wcnt0 >= wait_n) || spur;
    assign ack1  = (req1 && wcnt1 >= wait_n) || spur;
    assign data0 = prog0[addr0];
    assign data1 = prog1[addr1];
    assign sw0   = sw_val[DW0-1:0];
    assign sw1   = sw_val[DW1-1:0];

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        wcnt0 <= (req0 && !ack0) ? wcnt0 + 1 : 0;
        wcnt1 <= (req1 && !ack1) ? wcnt1 + 1 : 0;
    end

    logic o_req, o_ack, o_valid, o_halt;
    logic [31:0] o_addr, o_out;
    always_comb begin
        if (sel == 0) begin
            o_req = req0; o_ack = ack0; o_valid = out_valid0; o_halt = halted0;
            o_addr = 32'(addr0); o_out = 32'(out0);
        end else begin
            o_req = req1; o_ack = ack1; o_valid = out_valid1; o_halt = halted1;
            o_addr = 32'(addr1); o_out = 32'(out1);
        end
    end

    td_core #(.DATA_W(DW0), .ADDR_W(AW0), .NREG(NR0)) dut0 (
        .clk(clk), .rst_n(rst_n), .run_en(run_en0), .imem_req(req0), .imem_addr(addr0),
        .imem_ack(ack0), .imem_data(data0), .sw_in(sw0), .out_port(out0),
        .out_valid(out_valid0), .halted(halted0)
    );

    td_core #(.DATA_W(DW1), .ADDR_W(AW1), .NREG(NR1)) dut1 (
        .clk(clk), .rst_n(rst_n), .run_en(run_en1), .imem_req(req1), .imem_addr(addr1),
        .imem_ack(ack1), .imem_data(data1), .sw_in(sw1), .out_port(out1),
        .out_valid(out_valid1), .halted(halted1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic use_dut(input int s);
        sel = s;
        dw  = (s == 0) ? DW0 : DW1;
        aw  = (s == 0) ? AW0 : AW1;
        nr  = (s == 0) ? NR0 : NR1;
        rs  = (nr > 1) ? $clog2(nr) : 1;
    endtask

    function automatic logic [31:0] enc(input int op, input int d, input int s, input int imm);
        return 32'((op << (2 * rs + dw)) | (d << (rs + dw)) | (s << dw) | (imm & ((1 << dw) - 1)));
    endfunction

    task automatic put(input int a, input logic [31:0] ins);
        if (sel == 0) prog0[a] = ins[IW0-1:0];
        else          prog1[a] = ins[IW1-1:0];
    endtask

    function automatic logic [31:0] get_prog(input int a);
        return (sel == 0) ? 32'(prog0[a]) : 32'(prog1[a]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mr[i] = 0;
        mcf = 0; mip = 0; mout = 0; mvalid = 0; mhalt = 0;
    endtask

    task automatic model_wr(input int d, input int v);
        if (d < nr) mr[d] = v;
    endtask

    // Reference semantics of one instruction, plain integer arithmetic.
    task automatic model_step(input logic [31:0] ins, input int swv);
        int op, d, s, imm, mask, am, a, b, sum, old_cf;
        mask = (1 << dw) - 1;
        am   = (1 << aw) - 1;
        op   = int'(ins >> (2 * rs + dw)) & 15;
        d    = int'(ins >> (rs + dw)) & ((1 << rs) - 1);
        s    = int'(ins >> dw) & ((1 << rs) - 1);
        imm  = int'(ins) & mask;
        a    = (d < nr) ? mr[d] : 0;
        b    = (s < nr) ? mr[s] : 0;
        old_cf = mcf;
        mcf    = 0;
        mvalid = 0;
        mip    = (mip + 1) & am;
        case (op)
            0:  begin sum = a + imm; mcf = (sum > mask) ? 1 : 0; model_wr(d, sum & mask); end
            1:  model_wr(d, imm);
            2:  model_wr(d, b);
            3:  model_wr(d, swv & mask);
            4:  begin mout = b; mvalid = 1; end
            5:  begin mout = imm; mvalid = 1; end
            6:  mip = imm & am;
            7:  if (old_cf == 0) mip = imm & am;
            8:  begin sum = a + b; mcf = (sum > mask) ? 1 : 0; model_wr(d, sum & mask); end
            9:  begin mcf = (imm > a) ? 1 : 0; model_wr(d, (a - imm) & mask); end
            10: mhalt = 1;
            default: ;
        endcase
    endtask

    // Waits for the fetch handshake, then checks EXEC and the architectural result.
    task automatic step_instr(input int new_sw, input int wait_cycles, input int budget);
        int n = 0;
        bit seen_req = 0;
        int old_sw;
        logic [31:0] ins;
        wait_n = wait_cycles;
        #1;
        while (!(o_req && o_ack)) begin
            if (o_req) seen_req = 1;
            if (n >= budget) begin
                chk("fetch_timeout", o_req && o_ack, 1);
                return;
            end
            @(negedge clk);
            n++;
            if (seen_req && drop_run) begin run_en0 = 0; run_en1 = 0; end
            #1;
            if (seen_req) begin
                chk("req_hold", o_req, 1);
                chk("addr_hold", o_addr, mip);
            end
        end
        last_fetch_cyc = cyc;
        chk("fetch_addr", o_addr, mip);
        ins    = get_prog(mip);
        old_sw = sw_val;
        if (new_sw >= 0) sw_val = new_sw;
        @(negedge clk);
`ifndef IN_SYNC_EN
        if (rand_sw) sw_val = $urandom_range(0, 255);
`endif
        #1;
        chk("req_drop", o_req, 0);
        chk("valid_idle", o_valid, 0);
`ifdef IN_SYNC_EN
        model_step(ins, (new_sw >= 0) ? old_sw : sw_val);
`else
        model_step(ins, sw_val);
`endif
        @(negedge clk);
        #1;
        last_chk_cyc = cyc;
        chk("out_valid", o_valid, mvalid);
        chk("out_port", o_out, mout);
        chk("halted", o_halt, mhalt);
        chk("ip", o_addr, mip);
    endtask

    task automatic do_reset();
        run_en0 = 0; run_en1 = 0; spur = 0; wait_n = 0;
        @(negedge clk);
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    task automatic load_random(input int depth);
        int op;
        for (int i = 0; i < depth; i++) begin
            op = $urandom_range(0, 14);
            if (op >= 10) op++;
            put(i, enc(op, $urandom_range(0, (1 << rs) - 1), $urandom_range(0, (1 << rs) - 1),
                       $urandom_range(0, 255)));
        end
    endtask

    initial begin
        rst_n = 0; run_en0 = 1; run_en1 = 1; sw_val = 5;
        use_dut(1);
        for (int i = 0; i < 64; i++) put(i, enc(11, 0, 0, 0));
        use_dut(0);
        for (int i = 0; i < 16; i++) put(i, enc(11, 0, 0, 0));
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req0", req0, 0);
        chk("rst_addr0", 32'(addr0), 0);
        chk("rst_out0", 32'(out0), 0);
        chk("rst_valid0", out_valid0, 0);
        chk("rst_halted0", halted0, 0);
        chk("rst_req1", req1, 0);
        chk("rst_addr1", 32'(addr1), 0);
        chk("rst_out1", 32'(out1), 0);
        chk("rst_halted1", halted1, 0);

        // Default core, zero-wait memory, directed program.
        do_reset();
        put(0,  enc(1, 0, 0, 3));
        put(1,  enc(0, 0, 0, 14));
        put(2,  enc(7, 0, 0, 0));
        put(3,  enc(4, 0, 0, 0));
        put(4,  enc(1, 1, 0, 2));
        put(5,  enc(9, 1, 0, 5));
        put(6,  enc(1, 0, 0, 0));
        put(7,  enc(7, 0, 0, 9));
        put(8,  enc(5, 0, 0, 15));
        put(9,  enc(4, 0, 1, 0));
        put(10, enc(4, 0, 1, 0));
        put(11, enc(3, 0, 0, 0));
        put(12, enc(4, 0, 0, 0));
        put(13, enc(8, 0, 1, 0));
        put(14, enc(2, 1, 0, 0));
        put(15, enc(4, 0, 1, 0));
        run_en0 = 1;
        step_instr(-1, 0, 20);
        t0 = last_fetch_cyc;
        step_instr(-1, 0, 20);
        step_instr(-1, 0, 20);
        step_instr(-1, 0, 20);
        chk("out_reg_r0", o_out, 1);
        chk("prog_cycles", last_chk_cyc - t0, 8);
        for (int i = 0; i < 4; i++) step_instr(-1, 0, 20);
        chk("jnc_taken", o_addr, 9);
        step_instr(-1, 0, 20);
        chk("sub_borrow_val", o_out, 13);
        step_instr(-1, 0, 20);
        chk("repeat_pulse", o_valid, 1);
        step_instr(10, 0, 20);
        step_instr(-1, 0, 20);
`ifdef IN_SYNC_EN
        chk("in_sample", o_out, 5);
`else
        chk("in_sample", o_out, 10);
`endif
        for (int i = 0; i < 3; i++) step_instr(-1, 0, 20);
        chk("ip_wrap", o_addr, 0);
        step_instr(-1, 0, 20);
        run_en0 = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("idle_no_req", o_req, 0);

        // Slow memory with run_en dropped while the request is outstanding.
        run_en0  = 1;
        drop_run = 1;
        step_instr(-1, 3, 20);
        drop_run = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("no_req_after", o_req, 0);
        end
        spur = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("spur_ignored", o_addr, mip);
            chk("spur_no_valid", o_valid, 0);
        end
        spur = 0;

        // HALT, then an asynchronous reset from HALT.
        put(mip, enc(10, 0, 0, 0));
        run_en0 = 1;
        step_instr(-1, 0, 20);
        chk("halt_set", o_halt, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            chk("halt_no_req", o_req, 0);
        end
        #2 rst_n = 0;
        #1;
        chk("arst_halted", o_halt, 0);
        chk("arst_out", o_out, 0);
        chk("arst_addr", o_addr, 0);
        chk("arst_req", o_req, 0);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        step_instr(-1, 0, 20);
        step_instr(-1, 0, 20);

        // Reset while a request is outstanding.
        wait_n = 10;
        repeat (2) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_req_pending", o_req, 0);
        @(negedge clk);
        run_en0 = 0;
        rst_n   = 1;
        wait_n  = 0;
        model_reset();
        #1;
        chk("post_rst_idle", o_req, 0);

        // Random program on the default core.
        load_random(16);
        rand_sw = 1;
        run_en0 = 1;
        for (int i = 0; i < 60; i++) step_instr(-1, $urandom_range(0, 2), 20);
        run_en0 = 0;
        rand_sw = 0;

        // Wide core: 8-bit data, 6-bit address, 4 registers.
        use_dut(1);
        do_reset();
        put(0, enc(1, 2, 0, 200));
        put(1, enc(1, 3, 0, 100));
        put(2, enc(8, 3, 2, 0));
        put(3, enc(7, 0, 0, 10));
        put(4, enc(4, 0, 3, 0));
        put(5, enc(6, 0, 0, 63));
        put(63, enc(11, 0, 0, 0));
        run_en1 = 1;
        for (int i = 0; i < 5; i++) step_instr(-1, 0, 20);
        chk("add_reg_r3", o_out, 44);
        step_instr(-1, 0, 20);
        chk("jmp_63", o_addr, 63);
        step_instr(-1, 0, 20);
        chk("wide_wrap", o_addr, 0);
        run_en1 = 0;
        repeat (2) @(negedge clk);
        load_random(64);
        rand_sw = 1;
        run_en1 = 1;
        for (int i = 0; i < 60; i++) step_instr(-1, $urandom_range(0, 2), 20);
        run_en1 = 0;
        rand_sw = 0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
